// File: rtl/parking_entry_scheduler_pkg.sv
// Shared types and constants for the two-lane parking entry scheduler.
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_OPEN    = 2'd2,
    ST_BLOCKED = 2'd3
  } state_t;

  localparam logic [15:0] DEF_PIN       = 16'h5990;
  localparam int          DEF_MAX_TRIES = 3;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;

endpackage

// File: rtl/parking_rr_arbiter.sv
// Two-request round-robin arbiter; remembers the last lane that completed an entry.
module parking_rr_arbiter
  import parking_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_lane,
  output logic [1:0] o_gnt
);

  logic r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'(LANE_B);
    end else if (i_update) begin
      r_last <= i_lane;
    end
  end

  // On a tie the lane that did not enter last wins.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == 1'(LANE_B)) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/parking_entry_scheduler.sv
// Entry scheduler: arbitrates two lanes onto one PIN checker and barrier gate,
// runs the PIN-attempt sequence and tracks lot occupancy.
module parking_entry_scheduler
  import parking_pkg::*;
#(
  parameter logic [15:0] PIN       = DEF_PIN,
  parameter int          MAX_TRIES = DEF_MAX_TRIES,
  parameter int          CAPACITY  = 8,
  parameter int          CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       vehicle_arrival,
  input  logic [15:0]      code_a,
  input  logic [15:0]      code_b,
  input  logic [1:0]       code_ack,
  input  logic [1:0]       vehicle_left,
  input  logic             vehicle_exit,
  output logic [1:0]       grant,
  output logic             gate_open,
  output logic             wrong_pin,
  output logic             block_alarm,
  output logic             lot_full,
  output logic [CNT_W-1:0] occupancy
);

  localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

  state_t           r_state, w_state_nx;
  logic [1:0]       r_grant, w_grant_nx;
  logic             r_gate, w_gate_nx;
  logic             r_wrong, w_wrong_nx;
  logic             r_alarm, w_alarm_nx;
  logic [TRY_W-1:0] r_tries, w_tries_nx;
  logic [CNT_W-1:0] r_occ, w_occ_nx;
  logic [1:0]       r_ack_prev, r_left_prev;

  logic [1:0]  w_ack_rise, w_left_rise, w_req, w_pick;
  logic        w_full, w_entry, w_lane;
  logic        w_lane_arr, w_lane_ack, w_lane_left;
  logic [15:0] w_lane_code;

  assign w_ack_rise  = code_ack & ~r_ack_prev;
  assign w_left_rise = vehicle_left & ~r_left_prev;
  assign w_full      = (r_occ == CAP);

  assign w_lane      = r_grant[LANE_B];
  assign w_lane_arr  = vehicle_arrival[w_lane];
  assign w_lane_ack  = w_ack_rise[w_lane];
  assign w_lane_left = w_left_rise[w_lane];
  assign w_lane_code = w_lane ? code_b : code_a;

  // A full lot only gates new grants; lanes already in service finish.
  assign w_req = vehicle_arrival & {2{~w_full}};

  parking_rr_arbiter u_arb (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_req   (w_req),
    .i_update(w_entry),
    .i_lane  (w_lane),
    .o_gnt   (w_pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= 2'b00;
      r_gate      <= 1'b0;
      r_wrong     <= 1'b0;
      r_alarm     <= 1'b0;
      r_tries     <= '0;
      r_occ       <= '0;
      r_ack_prev  <= 2'b00;
      r_left_prev <= 2'b00;
    end else begin
      r_state     <= w_state_nx;
      r_grant     <= w_grant_nx;
      r_gate      <= w_gate_nx;
      r_wrong     <= w_wrong_nx;
      r_alarm     <= w_alarm_nx;
      r_tries     <= w_tries_nx;
      r_occ       <= w_occ_nx;
      r_ack_prev  <= code_ack;
      r_left_prev <= vehicle_left;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_gate_nx  = r_gate;
    w_wrong_nx = r_wrong;
    w_alarm_nx = r_alarm;
    w_tries_nx = r_tries;
    w_entry    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick != 2'b00) begin
          w_state_nx = ST_GRANTED;
          w_grant_nx = w_pick;
          w_tries_nx = '0;
          w_wrong_nx = 1'b0;
        end
      end
      ST_GRANTED: begin
        // Withdrawal takes precedence over a simultaneous attempt.
        if (!w_lane_arr) begin
          w_state_nx = ST_IDLE;
          w_grant_nx = 2'b00;
          w_wrong_nx = 1'b0;
          w_tries_nx = '0;
        end else if (w_lane_ack) begin
          if (w_lane_code == PIN) begin
            w_state_nx = ST_OPEN;
            w_gate_nx  = 1'b1;
            w_wrong_nx = 1'b0;
            w_tries_nx = '0;
          end else if (r_tries == LAST_TRY) begin
            w_state_nx = ST_BLOCKED;
            w_alarm_nx = 1'b1;
            w_gate_nx  = 1'b0;
            w_wrong_nx = 1'b0;
          end else begin
            w_tries_nx = r_tries + 1'b1;
            w_wrong_nx = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (w_lane_left) begin
          w_state_nx = ST_IDLE;
          w_gate_nx  = 1'b0;
          w_grant_nx = 2'b00;
          w_entry    = 1'b1;
        end
      end
      ST_BLOCKED: begin
        w_gate_nx  = 1'b0;
        w_alarm_nx = 1'b1;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_grant_nx = 2'b00;
        w_gate_nx  = 1'b0;
      end
    endcase
  end

  // Occupancy saturates at both ends; a simultaneous entry and exit cancel.
  always_comb begin
    w_occ_nx = r_occ;
    if (w_entry && !vehicle_exit) begin
      if (r_occ != CAP) w_occ_nx = r_occ + 1'b1;
    end else if (vehicle_exit && !w_entry) begin
      if (r_occ != '0) w_occ_nx = r_occ - 1'b1;
    end
  end

  assign grant       = r_grant;
  assign gate_open   = r_gate;
  assign wrong_pin   = r_wrong;
  assign block_alarm = r_alarm;
  assign lot_full    = w_full;
  assign occupancy   = r_occ;

endmodule

// File: tb/tb_parking_entry_scheduler.sv
// Self-checking bench for parking_entry_scheduler: vector table, directed corner
// sequences and randomized traffic against a behavioural lot model.
module tb_parking_entry_scheduler;

  localparam logic [15:0] PIN  = 16'h5990;
  localparam int          MAXT = 3;
  localparam int          CAP  = 2;

  logic        clk;
  logic        rst;
  logic [1:0]  drv_arr, drv_ack, drv_left;
  logic [15:0] drv_ca, drv_cb;
  logic        drv_ex;
  logic [1:0]  grant;
  logic        gate_open, wrong_pin, block_alarm, lot_full;
  logic [3:0]  occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  parking_entry_scheduler #(.PIN(PIN), .MAX_TRIES(MAXT), .CAPACITY(CAP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .vehicle_arrival(drv_arr), .code_a(drv_ca), .code_b(drv_cb),
    .code_ack(drv_ack), .vehicle_left(drv_left), .vehicle_exit(drv_ex),
    .grant(grant), .gate_open(gate_open), .wrong_pin(wrong_pin),
    .block_alarm(block_alarm), .lot_full(lot_full), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: which lane is being served, and what it is doing.
  int   m_lane, m_tries, m_occ, m_last;
  bit   m_open, m_blocked, m_wrong;
  logic [1:0] m_pack, m_pleft;

  task automatic model_reset();
    m_lane = -1; m_tries = 0; m_occ = 0; m_last = 1;
    m_open = 0; m_blocked = 0; m_wrong = 0;
    m_pack = 2'b00; m_pleft = 2'b00;
  endtask

  task automatic model_step();
    logic [1:0]  ack_rise, left_rise;
    logic [15:0] code;
    bit entered;
    ack_rise  = drv_ack & ~m_pack;
    left_rise = drv_left & ~m_pleft;
    entered   = 0;
    if (m_blocked) begin
    end else if (m_lane < 0) begin
      if (m_occ < CAP && drv_arr != 2'b00) begin
        if (drv_arr == 2'b01)      m_lane = 0;
        else if (drv_arr == 2'b10) m_lane = 1;
        else                       m_lane = 1 - m_last;
        m_tries = 0; m_wrong = 0;
      end
    end else if (!m_open) begin
      if (!drv_arr[m_lane]) begin
        m_lane = -1; m_wrong = 0; m_tries = 0;
      end else if (ack_rise[m_lane]) begin
        code = (m_lane == 1) ? drv_cb : drv_ca;
        if (code == PIN) begin
          m_open = 1; m_wrong = 0; m_tries = 0;
        end else if (m_tries + 1 < MAXT) begin
          m_tries++; m_wrong = 1;
        end else begin
          m_blocked = 1; m_wrong = 0;
        end
      end
    end else if (left_rise[m_lane]) begin
      m_open = 0; m_last = m_lane; m_lane = -1; entered = 1;
    end
    if (entered && !drv_ex)      m_occ = (m_occ + 1 > CAP) ? CAP : m_occ + 1;
    else if (drv_ex && !entered) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
    m_pack  = drv_ack;
    m_pleft = drv_left;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("grant",       32'(grant),       (m_lane < 0) ? 32'd0 : (m_lane == 0 ? 32'd1 : 32'd2));
    chk("gate_open",   32'(gate_open),   32'(m_open));
    chk("wrong_pin",   32'(wrong_pin),   32'(m_wrong));
    chk("block_alarm", 32'(block_alarm), 32'(m_blocked));
    chk("lot_full",    32'(lot_full),    32'(m_occ == CAP));
    chk("occupancy",   32'(occupancy),   32'(m_occ));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    compare_model();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_inputs();
    drv_arr = 2'b00; drv_ack = 2'b00; drv_left = 2'b00;
    drv_ca = 16'h0; drv_cb = 16'h0; drv_ex = 1'b0;
  endtask

  task automatic enter(input int lane, input bit ex_at_close);
    drv_arr[lane] = 1'b1;
    cyc();
    if (lane == 0) drv_ca = PIN; else drv_cb = PIN;
    drv_ack[lane] = 1'b1;
    cyc();
    drv_ack[lane] = 1'b0; drv_left[lane] = 1'b1; drv_arr[lane] = 1'b0; drv_ex = ex_at_close;
    cyc();
    drv_left[lane] = 1'b0; drv_ex = 1'b0;
    cyc();
  endtask

  typedef struct {
    logic [1:0] arr; logic [15:0] ca; logic [15:0] cb; logic [1:0] ack; logic [1:0] left; logic ex;
    logic [1:0] g; logic gate; logic wr; logic al; logic full; logic [3:0] occ;
  } vec_t;
  vec_t tbl[9];
  logic [15:0] bad[3];

  initial begin
    rst = 1'b1;
    clear_inputs();
    tbl[0] = '{2'b01, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{2'b01, 16'h5990, 16'h0000, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[2] = '{2'b01, 16'h5990, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[3] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[4] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[5] = '{2'b10, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[6] = '{2'b10, 16'h0000, 16'h1234, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[7] = '{2'b00, 16'h0000, 16'h1234, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[8] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    bad[0] = 16'h1234; bad[1] = 16'h3145; bad[2] = 16'h4321;

    #2;
    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_occ",   32'(occupancy), 32'd0);

    // Normal entry, single lane B request, one wrong attempt and withdrawal.
    for (int i = 0; i < 9; i++) begin
      drv_arr = tbl[i].arr; drv_ca = tbl[i].ca; drv_cb = tbl[i].cb;
      drv_ack = tbl[i].ack; drv_left = tbl[i].left; drv_ex = tbl[i].ex;
      cyc();
      chk($sformatf("tbl%0d_grant", i), 32'(grant),       32'(tbl[i].g));
      chk($sformatf("tbl%0d_gate", i),  32'(gate_open),   32'(tbl[i].gate));
      chk($sformatf("tbl%0d_wrong", i), 32'(wrong_pin),   32'(tbl[i].wr));
      chk($sformatf("tbl%0d_alarm", i), 32'(block_alarm), 32'(tbl[i].al));
      chk($sformatf("tbl%0d_full", i),  32'(lot_full),    32'(tbl[i].full));
      chk($sformatf("tbl%0d_occ", i),   32'(occupancy),   32'(tbl[i].occ));
    end

    // Two wrong PINs then withdrawal.
    clear_inputs();
    do_reset();
    drv_arr = 2'b01; cyc();
    for (int i = 0; i < 2; i++) begin
      drv_ca = bad[i]; drv_ack = 2'b01; cyc();
      chk("two_wrong_pin", 32'(wrong_pin), 32'd1);
      chk("two_wrong_alarm", 32'(block_alarm), 32'd0);
      drv_ack = 2'b00; cyc();
    end
    drv_arr = 2'b00; cyc();
    chk("withdraw_grant", 32'(grant), 32'd0);
    chk("withdraw_wrong", 32'(wrong_pin), 32'd0);

    // Three wrong PINs lock the lot; a correct fourth attempt is ignored.
    clear_inputs();
    do_reset();
    enter(0, 1'b0);
    drv_arr = 2'b01; cyc();
    for (int i = 0; i < 3; i++) begin
      drv_ca = bad[i]; drv_ack = 2'b01; cyc();
      chk("three_wrong_alarm", 32'(block_alarm), (i == 2) ? 32'd1 : 32'd0);
      drv_ack = 2'b00; cyc();
    end
    drv_ca = PIN; drv_ack = 2'b01; cyc();
    chk("blocked_gate", 32'(gate_open), 32'd0);
    chk("blocked_grant_holds", 32'(grant), 32'd1);
    drv_ack = 2'b00;
    do_reset();
    chk("unblock_alarm", 32'(block_alarm), 32'd0);
    chk("unblock_occ", 32'(occupancy), 32'd0);

    // Tie goes to lane A first, then round-robin to B.
    clear_inputs();
    do_reset();
    drv_arr = 2'b11; cyc();
    chk("tie_first", 32'(grant), 32'd1);
    drv_ca = PIN; drv_ack = 2'b01; cyc();
    drv_ack = 2'b00; drv_left = 2'b01; cyc();
    drv_left = 2'b00; cyc();
    chk("tie_second", 32'(grant), 32'd2);

    // Capacity limit, exit release and simultaneous entry/exit.
    clear_inputs();
    do_reset();
    enter(0, 1'b0);
    enter(1, 1'b0);
    chk("cap_full", 32'(lot_full), 32'd1);
    drv_arr = 2'b01; cyc();
    chk("cap_no_grant", 32'(grant), 32'd0);
    drv_ex = 1'b1; cyc();
    chk("cap_exit_occ", 32'(occupancy), 32'd1);
    drv_ex = 1'b0; cyc();
    chk("cap_grant_after_exit", 32'(grant), 32'd1);
    enter(0, 1'b1);
    chk("cap_entry_exit_same", 32'(occupancy), 32'd1);

    // Asynchronous reset while the gate is open.
    clear_inputs();
    drv_arr = 2'b10; cyc();
    drv_cb = PIN; drv_ack = 2'b10; cyc();
    chk("open_before_rst", 32'(gate_open), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_gate", 32'(gate_open), 32'd0);
    chk("async_rst_grant", 32'(grant), 32'd0);
    clear_inputs();
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (m_blocked && ($urandom % 4 == 0)) do_reset();
      for (int b = 0; b < 2; b++) begin
        if ($urandom % 8 == 0) drv_arr[b] = ~drv_arr[b];
        if ($urandom % 3 == 0) drv_ack[b] = ~drv_ack[b];
        if ($urandom % 4 == 0) drv_left[b] = ~drv_left[b];
      end
      drv_ca = ($urandom % 2 == 0) ? PIN : 16'($urandom);
      drv_cb = ($urandom % 2 == 0) ? PIN : 16'($urandom);
      drv_ex = ($urandom % 6 == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
